// File: rtl/flag_ctrl.sv
// flag_ctrl: pipeline controller for the 3-bit flag register {N,V,Z}.
// Decodes per-instruction flag write masks in ID, carries them into EX,
// drives the flag register write port, and stalls conditional branches
// for one cycle while a flag write is still in flight.
module flag_ctrl #(
    parameter int NFLAG = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [3:0]       id_opcode,
    input  logic [2:0]       id_cond,
    input  logic             stall_in,
    input  logic             flush,
    input  logic [NFLAG-1:0] alu_flags,
    input  logic [NFLAG-1:0] flag_q,
    output logic [NFLAG-1:0] flag_wen,
    output logic [NFLAG-1:0] flag_din,
    output logic             flag_stall,
    output logic             branch_taken
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [NFLAG-1:0] ex_mask;
    logic [NFLAG-1:0] id_mask;
    logic             is_branch;
    logic             cond_true;
    logic             hazard;

    // Opcode to flag write mask (bit 0 = Z, bit 1 = V, bit 2 = N).
    always_comb begin
        id_mask = '0;
        case (id_opcode)
            4'b0000, 4'b0001:                   id_mask = 3'b111;
            4'b0010, 4'b0100, 4'b0101, 4'b0110: id_mask = 3'b001;
            default:                            id_mask = '0;
        endcase
    end

    // Branch condition evaluated against the committed flag register.
    always_comb begin
        cond_true = 1'b0;
        case (id_cond)
            3'b000:  cond_true = ~flag_q[0];
            3'b001:  cond_true = flag_q[0];
            3'b010:  cond_true = ~flag_q[0] & ~flag_q[2];
            3'b011:  cond_true = flag_q[2];
            3'b100:  cond_true = flag_q[0] | ~flag_q[2];
            3'b101:  cond_true = flag_q[2] | flag_q[0];
            3'b110:  cond_true = flag_q[1];
            default: cond_true = 1'b1;
        endcase
    end

    // Hazard detection, stall/branch outputs and next-state selection.
    always_comb begin
        state_nxt    = state;
        is_branch    = id_valid && (id_opcode == 4'b1100 || id_opcode == 4'b1101);
        hazard       = is_branch && (id_cond != 3'b111) && (ex_mask != '0) && (state == IDLE);
        flag_stall   = hazard && !flush;
        branch_taken = is_branch && cond_true && !hazard && !stall_in && !flush;
        case (state)
            IDLE:    state_nxt = (hazard && !stall_in && !flush) ? WAIT : IDLE;
            WAIT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush)
            state_nxt = IDLE;
    end

    // State register and ID/EX write mask; anything not issued becomes a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ex_mask <= '0;
        end else begin
            state   <= state_nxt;
            ex_mask <= (id_valid && !stall_in && !flush && !flag_stall) ? id_mask : '0;
        end
    end

    assign flag_wen = ex_mask;
    assign flag_din = alu_flags;

endmodule

// File: tb/tb_flag_ctrl.sv
// tb_flag_ctrl: table-driven check of flag_ctrl plus short sequences that
// model the flag register to confirm masked writes commit correctly.
module tb_flag_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [3:0] id_opcode;
    logic [2:0] id_cond;
    logic       stall_in;
    logic       flush;
    logic [2:0] alu_flags;
    logic [2:0] flag_q;
    logic [2:0] flag_wen;
    logic [2:0] flag_din;
    logic       flag_stall;
    logic       branch_taken;

    int checks   = 0;
    int failures = 0;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_NOP = 4'b1111;
    localparam logic [3:0] OP_BR  = 4'b1100;
    localparam logic [3:0] OP_BRU = 4'b1101;

    flag_ctrl #(.NFLAG(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_opcode    (id_opcode),
        .id_cond      (id_cond),
        .stall_in     (stall_in),
        .flush        (flush),
        .alu_flags    (alu_flags),
        .flag_q       (flag_q),
        .flag_wen     (flag_wen),
        .flag_din     (flag_din),
        .flag_stall   (flag_stall),
        .branch_taken (branch_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [3:0] op;
        logic [2:0] cond;
        logic       stl;
        logic       fl;
        logic [2:0] alu;
        logic [2:0] fq;
        logic [2:0] e_wen;
        logic [2:0] e_din;
        logic       e_stall;
        logic       e_taken;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic v, input logic [3:0] op, input logic [2:0] c,
                       input logic s, input logic f, input logic [2:0] alu, input logic [2:0] fq,
                       input logic [2:0] ew, input logic [2:0] ed, input logic es, input logic et);
        vec_t x;
        x.rst = r; x.vld = v; x.op = op; x.cond = c; x.stl = s; x.fl = f;
        x.alu = alu; x.fq = fq; x.e_wen = ew; x.e_din = ed; x.e_stall = es; x.e_taken = et;
        vecs.push_back(x);
    endtask

    task automatic drive(input logic r, input logic v, input logic [3:0] op, input logic [2:0] c,
                         input logic s, input logic f, input logic [2:0] alu, input logic [2:0] fq);
        @(negedge clk);
        rst = r; id_valid = v; id_opcode = op; id_cond = c;
        stall_in = s; flush = f; alu_flags = alu; flag_q = fq;
        #1;
    endtask

    task automatic check3(input string name, input int idx, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic check1(input string name, input int idx, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    logic [2:0] freg;

    // Drive one cycle with flag_q taken from the modelled register, then commit the write.
    task automatic reg_cycle(input logic v, input logic [3:0] op, input logic [2:0] alu);
        drive(1'b0, v, op, 3'b111, 1'b0, 1'b0, alu, freg);
        freg = (freg & ~flag_wen) | (flag_din & flag_wen);
    endtask

    initial begin
        rst = 1'b1; id_valid = 1'b0; id_opcode = OP_NOP; id_cond = 3'b000;
        stall_in = 1'b0; flush = 1'b0; alu_flags = 3'b000; flag_q = 3'b000;
        repeat (2) @(posedge clk);

        //   rst vld op      cond    stl fl  alu     fq      wen     din     stall taken
        add(1, 0, OP_NOP, 3'b000, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0); // reset state
        add(0, 1, OP_ADD, 3'b000, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0);
        add(0, 0, OP_NOP, 3'b000, 0, 0, 3'b101, 3'b000, 3'b111, 3'b101, 0, 0); // ADD in EX
        add(0, 0, OP_NOP, 3'b000, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0);
        add(0, 1, OP_XOR, 3'b000, 0, 0, 3'b110, 3'b000, 3'b000, 3'b110, 0, 0);
        add(0, 0, OP_NOP, 3'b000, 0, 0, 3'b110, 3'b000, 3'b001, 3'b110, 0, 0); // Z only
        add(0, 1, OP_ADD, 3'b000, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0);
        add(0, 1, OP_BR,  3'b001, 0, 0, 3'b001, 3'b000, 3'b111, 3'b001, 1, 0); // EQ hazard
        add(0, 1, OP_BR,  3'b001, 0, 0, 3'b000, 3'b001, 3'b000, 3'b000, 0, 1); // WAIT resolves
        add(0, 1, OP_ADD, 3'b000, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0);
        add(0, 1, OP_BRU, 3'b111, 0, 0, 3'b000, 3'b000, 3'b111, 3'b000, 0, 1); // always: no stall
        add(0, 1, OP_BR,  3'b010, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 1); // GT 000
        add(0, 1, OP_BR,  3'b010, 0, 0, 3'b000, 3'b100, 3'b000, 3'b000, 0, 0); // GT N=1
        add(0, 1, OP_BR,  3'b110, 0, 0, 3'b000, 3'b010, 3'b000, 3'b000, 0, 1); // OV
        add(0, 1, OP_BR,  3'b100, 0, 0, 3'b000, 3'b100, 3'b000, 3'b000, 0, 0); // GE Z0 N1
        add(0, 1, OP_BR,  3'b100, 0, 0, 3'b000, 3'b101, 3'b000, 3'b000, 0, 1); // GE Z1
        add(0, 1, OP_BR,  3'b101, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0); // LE false
        add(0, 1, OP_BR,  3'b000, 0, 0, 3'b000, 3'b001, 3'b000, 3'b000, 0, 0); // NE Z=1
        add(0, 0, OP_BR,  3'b111, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0); // invalid ID
        add(0, 1, OP_SUB, 3'b000, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0);
        add(0, 1, OP_BR,  3'b000, 0, 1, 3'b000, 3'b000, 3'b111, 3'b000, 0, 0); // flush on hazard
        add(0, 1, OP_BR,  3'b000, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 1); // IDLE, mask cleared
        add(0, 1, OP_SUB, 3'b000, 1, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0); // SUB held
        add(0, 0, OP_NOP, 3'b000, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0); // bubble
        add(0, 1, OP_ADD, 3'b000, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0);
        add(0, 1, OP_BR,  3'b011, 1, 0, 3'b000, 3'b100, 3'b111, 3'b000, 1, 0); // stall_in on hazard
        add(0, 1, OP_BR,  3'b011, 0, 0, 3'b000, 3'b100, 3'b000, 3'b000, 0, 1); // stayed IDLE
        add(0, 1, OP_ADD, 3'b000, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0);
        add(0, 1, OP_XOR, 3'b000, 0, 0, 3'b101, 3'b000, 3'b111, 3'b101, 0, 0); // back-to-back
        add(0, 0, OP_NOP, 3'b000, 0, 0, 3'b110, 3'b000, 3'b001, 3'b110, 0, 0);
        add(0, 1, OP_ADD, 3'b000, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0);
        add(0, 1, OP_BR,  3'b001, 0, 0, 3'b000, 3'b000, 3'b111, 3'b000, 1, 0); // hazard -> WAIT
        add(1, 1, OP_BR,  3'b001, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0); // rst in WAIT
        add(0, 0, OP_NOP, 3'b000, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0);
        add(0, 1, OP_ADD, 3'b000, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0);
        add(1, 0, OP_NOP, 3'b000, 0, 0, 3'b011, 3'b000, 3'b111, 3'b011, 0, 0); // rst drops write
        add(0, 0, OP_NOP, 3'b000, 0, 0, 3'b011, 3'b000, 3'b000, 3'b011, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].vld, vecs[i].op, vecs[i].cond,
                  vecs[i].stl, vecs[i].fl, vecs[i].alu, vecs[i].fq);
            check3("flag_wen", i, flag_wen, vecs[i].e_wen);
            check3("flag_din", i, flag_din, vecs[i].e_din);
            check1("flag_stall", i, flag_stall, vecs[i].e_stall);
            check1("branch_taken", i, branch_taken, vecs[i].e_taken);
        end

        // XOR with alu=110 over register 000: only Z written, register stays 000.
        drive(1'b1, 1'b0, OP_NOP, 3'b111, 1'b0, 1'b0, 3'b000, 3'b000);
        freg = 3'b000;
        reg_cycle(1'b1, OP_XOR, 3'b000);
        reg_cycle(1'b0, OP_NOP, 3'b110);
        check3("xor_reg", 100, freg, 3'b000);

        // ADD (110) then XOR (001): N,V from ADD, Z from XOR -> 111.
        reg_cycle(1'b1, OP_ADD, 3'b000);
        reg_cycle(1'b1, OP_XOR, 3'b110);
        check3("add_reg", 101, freg, 3'b110);
        reg_cycle(1'b0, OP_NOP, 3'b001);
        check3("add_xor_reg", 102, freg, 3'b111);

        // SUB (011) then branch EQ: stall, then resolve on committed Z=1.
        reg_cycle(1'b1, OP_SUB, 3'b000);
        drive(1'b0, 1'b1, OP_BR, 3'b001, 1'b0, 1'b0, 3'b011, freg);
        check1("seq_stall", 103, flag_stall, 1'b1);
        check1("seq_taken0", 104, branch_taken, 1'b0);
        freg = (freg & ~flag_wen) | (flag_din & flag_wen);
        drive(1'b0, 1'b1, OP_BR, 3'b001, 1'b0, 1'b0, 3'b000, freg);
        check1("seq_stall_wait", 105, flag_stall, 1'b0);
        check1("seq_taken1", 106, branch_taken, 1'b1);
        check3("seq_reg", 107, freg, 3'b011);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flag_ctrl.md
# flag_ctrl

Pipeline controller for the 3-bit processor flag register (bit 0 = Z, bit 1 = V, bit 2 = N).
- Decodes which flags each instruction writes and carries that write mask down the ID/EX stage.
- Drives the flag register's per-bit write enables and data from the EX stage.
- Stalls conditional branches in ID while a flag write is in flight, then resolves the branch against the committed flags.
- Sits between decode, the ALU flag outputs and the flag register instance.

## Interface
Parameters:
- NFLAG, 3, flag width. Fixed; other values are unsupported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  the ID-stage instruction is valid.
- id_opcode  in  4  ID-stage opcode.
- id_cond  in  3  ID-stage branch condition field.
- stall_in  in  1  external hazard stall (e.g. load-use); ID is held and a bubble enters EX.
- flush  in  1  squash the ID-stage instruction; a bubble enters EX.
- alu_flags  in  3  {N,V,Z} computed by the ALU for the EX-stage instruction.
- flag_q  in  3  current flag register contents.
- flag_wen  out  3  per-bit write enable to the flag register.
- flag_din  out  3  write data to the flag register.
- flag_stall  out  1  request to hold IF/ID for one cycle.
- branch_taken  out  1  a conditional or unconditional branch (opcode 1100/1101) in ID is taken this cycle.

## Operation
Opcode to write mask, decoded in ID:
- 0000 ADD and 0001 SUB: mask 111.
- 0010 XOR, 0100 SLL, 0101 SRA, 0110 ROR: mask 001 (Z only).
- All other opcodes: mask 000.

EX-stage write path:
- ex_mask register (3 bits) loads the ID mask when id_valid=1, stall_in=0, flush=0 and flag_stall=0.
- In every other cycle ex_mask loads 000 (bubble).
- flag_wen = ex_mask; flag_din = alu_flags. Bits with a zero enable leave the register unchanged.

Branch evaluation (ID, opcode 1100 or 1101):
- Condition encodings, evaluated on flag_q:
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 and N=0
  - 011 LT: N=1
  - 100 GE: Z=1, or Z=0 and N=0
  - 101 LE: N=1 or Z=1
  - 110 OV: V=1
  - 111 always
- A conditional branch (cond != 111) with ex_mask != 000 causes a hazard. In that cycle flag_stall=1 and branch_taken=0.
- cond = 111 never stalls.

FSM, 2 states:
- IDLE: on a hazard with stall_in=0 and flush=0, go to WAIT; otherwise stay.
- WAIT: ex_mask is 000 (bubble), so no hazard is possible. flag_stall=0 and the branch is evaluated on the updated flag_q. Always return to IDLE.

Priority:
- flush=1 forces flag_stall=0 and branch_taken=0, and the FSM goes to IDLE.
- stall_in=1 masks branch_taken to 0. flag_stall still reports a hazard, but the FSM stays IDLE.

Reset values:
- ex_mask = 000, FSM = IDLE.
- Therefore flag_wen = 000, flag_stall = 0, branch_taken = 0.
- flag_din follows alu_flags combinationally.

## Timing
- Write latency: a flag-writing instruction in ID at cycle t drives flag_wen during t+1, and the register updates at the end of t+1.
- Hazard penalty: exactly 1 cycle.
  - Branch in ID at t+1: flag_stall=1.
  - At t+2 (WAIT) the branch resolves using flags written at the end of t+1.
- Back-to-back writers: the second write wins on overlapping bits. An XOR following an ADD updates only Z; N and V keep the ADD result.
- rst asserted during WAIT: next cycle is IDLE with ex_mask=000, and the in-flight write is dropped.
- flag_stall and branch_taken are combinational from the registered state plus the ID inputs.

## Test plan
- Reset, then ADD with alu_flags=101 -> flag_wen=111 and flag_din=101 one cycle later. Next cycle after rst: flag_wen=000.
- XOR with alu_flags=110 while flag_q=000 -> flag_wen=001, flag_din=110, so the register becomes 000 (only Z is written).
- ADD (alu_flags=001) immediately followed by a branch EQ -> cycle t+1: flag_stall=1, branch_taken=0. Cycle t+2: flag_stall=0, branch_taken=1.
- ADD immediately followed by a branch with cond=111 -> no stall, branch_taken=1 in the branch's first ID cycle.
- Branch GT with flag_q=000 and ex_mask=000 -> branch_taken=1. With flag_q=100 -> branch_taken=0. Branch OV with flag_q=010 -> branch_taken=1.
- Hazard cycle with flush=1 -> flag_stall=0, FSM stays IDLE, next ex_mask=000. SUB in ID with stall_in=1 -> next flag_wen=000.
